// File: rtl/pwm_define.sv
// Shared PWM definitions: timer register map, dead-time defaults and the
// per-channel dead-time FSM state type.
package pwm_define;

    // Timer register map (byte offsets)
    localparam logic [7:0] PWM_REG_CTRL     = 8'h00;
    localparam logic [7:0] PWM_REG_PERIOD   = 8'h04;
    localparam logic [7:0] PWM_REG_DUTY0    = 8'h08;
    localparam logic [7:0] PWM_REG_DEADTIME = 8'h0C;
    localparam logic [7:0] PWM_REG_STATUS   = 8'h10;

    // Default width of the dead-time count
    localparam int DT_WIDTH_DEF = 8;

    // Per-channel dead-time insertion states
    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_LOW_ON  = 3'd1,
        ST_DEAD_R  = 3'd2,
        ST_HIGH_ON = 3'd3,
        ST_DEAD_F  = 3'd4
    } dt_state_e;

endpackage

// File: rtl/dffer.sv
// Shared register cell: D flop with load enable and asynchronous
// active-low reset to zero.
module dffer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d only when enabled, clear asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/dffr.sv
// Shared register cell: D flop with asynchronous active-low reset to zero.
module dffr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d every cycle, clear asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= d;
    end

endmodule

// File: rtl/pwm_dt_ch.sv
// One dead-time channel: turns a raw PWM level into complementary
// high/low gate drives with a programmable both-off gap between them.
// Gate outputs come straight from flops loaded with the decode of the
// next state, so they can never glitch and never both be high.
module pwm_dt_ch
    import pwm_define::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [DT_WIDTH-1:0] dt,
    input  logic                pwm,
    output logic                pwm_h,
    output logic                pwm_l
);

    localparam logic [DT_WIDTH-1:0] CNT_ONE = DT_WIDTH'(1);

    dt_state_e           state;
    dt_state_e           state_nxt;
    logic [2:0]          state_q;
    logic [DT_WIDTH-1:0] cnt;
    logic [DT_WIDTH-1:0] cnt_d;
    logic                cnt_en;
    logic                h_d;
    logic                l_d;

    dffr #(.W(3)) u_state (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (state_nxt),
        .q     (state_q)
    );

    assign state = dt_state_e'(state_q);

    dffer #(.W(DT_WIDTH)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en),
        .d     (cnt_d),
        .q     (cnt)
    );

    dffr #(.W(1)) u_h (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (h_d),
        .q     (pwm_h)
    );

    dffr #(.W(1)) u_l (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (l_d),
        .q     (pwm_l)
    );

    // Next state and counter control; disable overrides everything.
    // dt is only sampled when a dead interval is loaded, so a change while
    // counting applies to the following transition.
    always_comb begin
        state_nxt = state;
        cnt_en    = 1'b0;
        cnt_d     = '0;
        if (!en) begin
            state_nxt = ST_OFF;
            cnt_en    = 1'b1;
        end else begin
            case (state)
                ST_OFF: state_nxt = ST_LOW_ON;
                ST_LOW_ON: begin
                    if (pwm) begin
                        if (dt == '0) begin
                            state_nxt = ST_HIGH_ON;
                        end else begin
                            state_nxt = ST_DEAD_R;
                            cnt_en    = 1'b1;
                            cnt_d     = dt - CNT_ONE;
                        end
                    end
                end
                ST_DEAD_R: begin
                    if (!pwm) begin
                        state_nxt = ST_LOW_ON;
                    end else if (cnt == '0) begin
                        state_nxt = ST_HIGH_ON;
                    end else begin
                        cnt_en = 1'b1;
                        cnt_d  = cnt - CNT_ONE;
                    end
                end
                ST_HIGH_ON: begin
                    if (!pwm) begin
                        if (dt == '0) begin
                            state_nxt = ST_LOW_ON;
                        end else begin
                            state_nxt = ST_DEAD_F;
                            cnt_en    = 1'b1;
                            cnt_d     = dt - CNT_ONE;
                        end
                    end
                end
                ST_DEAD_F: begin
                    if (pwm) begin
                        state_nxt = ST_HIGH_ON;
                    end else if (cnt == '0) begin
                        state_nxt = ST_LOW_ON;
                    end else begin
                        cnt_en = 1'b1;
                        cnt_d  = cnt - CNT_ONE;
                    end
                end
                default: state_nxt = ST_OFF;
            endcase
        end
    end

    // Gate drive decode of the next state, registered by the output flops
    always_comb begin
        h_d = (state_nxt == ST_HIGH_ON);
        l_d = (state_nxt == ST_LOW_ON);
    end

endmodule

// File: rtl/pwm_deadtime.sv
// Multi-channel dead-time inserter between a PWM timer and gate drivers.
// Optional feature: define PWM_DT_BRK_EN to add a latched break input
// (brk_i / brk_clr_i / brk_o) that forces every channel off until cleared.
module pwm_deadtime
    import pwm_define::*;
#(
    parameter int CH_NUM   = 4,
    parameter int DT_WIDTH = DT_WIDTH_DEF
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    input  logic [DT_WIDTH-1:0] dt_i,
    input  logic [CH_NUM-1:0]   pwm_i,
`ifdef PWM_DT_BRK_EN
    input  logic                brk_i,
    input  logic                brk_clr_i,
    output logic                brk_o,
`endif
    output logic [CH_NUM-1:0]   pwm_h_o,
    output logic [CH_NUM-1:0]   pwm_l_o
);

    logic ch_en;

`ifdef PWM_DT_BRK_EN
    logic brk_d;

    // Break latch: set wins over clear, clear only acts with break released
    always_comb begin
        brk_d = brk_i | (brk_o & ~brk_clr_i);
    end

    dffr #(.W(1)) u_brk (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .d     (brk_d),
        .q     (brk_o)
    );

    // A live or latched break holds every channel in OFF
    assign ch_en = en_i & ~brk_o & ~brk_i;
`else
    assign ch_en = en_i;
`endif

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        pwm_dt_ch #(.DT_WIDTH(DT_WIDTH)) u_ch (
            .clk   (clk_i),
            .rst_n (rst_n_i),
            .en    (ch_en),
            .dt    (dt_i),
            .pwm   (pwm_i[i]),
            .pwm_h (pwm_h_o[i]),
            .pwm_l (pwm_l_o[i])
        );
    end

endmodule

// File: doc/pwm_deadtime.md
PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, number of PWM channels.
REQ-002 SHALL have parameter DT_WIDTH, default 8, dead-time count width.
REQ-003 SHALL have clk_i, input, 1, the single clock.
REQ-004 SHALL have rst_n_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have en_i, input, 1, block enable; 0 forces all outputs off.
REQ-006 SHALL have dt_i, input, DT_WIDTH, dead time in clk_i cycles.
REQ-007 SHALL have pwm_i, input, CH_NUM, raw PWM from the upstream PWM timer, same clock domain.
REQ-008 SHALL have pwm_h_o, output, CH_NUM, high-side gate drive.
REQ-009 SHALL have pwm_l_o, output, CH_NUM, low-side gate drive.
REQ-010 SHALL have brk_i, brk_clr_i (input, 1) and brk_o (output, 1), present only with PWM_DT_BRK_EN.

Function
REQ-011 SHALL run one independent FSM per channel with states OFF, LOW_ON, DEAD_R, HIGH_ON, DEAD_F.
REQ-012 SHALL drive outputs from flops: OFF/DEAD_R/DEAD_F h=0,l=0; LOW_ON h=0,l=1; HIGH_ON h=1,l=0.
REQ-013 SHALL never assert pwm_h_o[n] and pwm_l_o[n] in the same cycle, for any input sequence.
REQ-014 SHALL move OFF->LOW_ON on the first cycle en_i=1, regardless of pwm_i.
REQ-015 SHALL, in LOW_ON with pwm_i=1: go to HIGH_ON if dt_i=0, else go to DEAD_R and load the counter with dt_i-1.
REQ-016 SHALL, in DEAD_R: go to LOW_ON if pwm_i=0 (pulse aborted); else go to HIGH_ON if count=0; else decrement.
REQ-017 SHALL treat HIGH_ON with pwm_i=0 and DEAD_F symmetrically to REQ-015/016, with high and low swapped.
REQ-018 SHALL keep both outputs low for exactly dt_i cycles per non-aborted transition.
REQ-019 SHALL add one cycle of latency from a pwm_i edge to the first output change.
REQ-020 SHALL sample dt_i only at counter load; a change mid-dead SHALL take effect on the next transition.
REQ-021 SHALL return every channel to OFF and clear its counter on the cycle after en_i=0; en_i has priority over pwm_i.
REQ-022 SHALL absorb an input pulse shorter than dt_i: the opposite side never turns on, and the original side re-asserts 1 cycle after the pulse ends.

Reset
REQ-023 SHALL reset all FSMs to OFF, counters to 0, pwm_h_o=0, pwm_l_o=0 and brk_o=0, asynchronously on rst_n_i=0.
REQ-024 SHALL force outputs to 0 immediately on a reset asserted mid-dead-time or mid-HIGH_ON, with no glitch to 1.

Configuration
REQ-025 SHALL, with PWM_DT_BRK_EN defined: latch brk_o=1 on brk_i=1; while brk_o=1 hold all channels in OFF; clear brk_o on brk_clr_i=1 only when brk_i=0; brk_i wins if both are 1.
REQ-026 SHALL, without PWM_DT_BRK_EN: omit the brk_i, brk_clr_i and brk_o ports and all break logic, with behaviour otherwise identical.

Structure
REQ-027 SHALL place the FSM state typedef and the default DT_WIDTH constant in the shared pwm_define.sv package, alongside the timer register defines.
REQ-028 SHALL implement one channel in sub-module pwm_dt_ch, instantiated CH_NUM times via generate.
REQ-029 SHALL use the shared dffr/dffer register cells for all state, counter and output flops.

Verification
REQ-030 SHALL check: dt_i=3, en_i=1, pwm_i[0] rises at cycle 10 -> l low at 11, both low at 11-13, h high at 14.
REQ-031 SHALL check: dt_i=0 -> h and l complement each other with 1-cycle latency, no overlap, no gap.
REQ-032 SHALL check: dt_i=5, 2-cycle high pulse on pwm_i -> h never 1, l re-asserts 1 cycle after the pulse ends.
REQ-033 SHALL check: en_i dropped while in HIGH_ON -> all h and l are 0 the next cycle; en_i restored -> LOW_ON.
REQ-034 SHALL check: 10k cycles of random pwm_i and dt_i on all 4 channels -> the h&l assertion never fires, and every dead gap equals its latched dt.
REQ-035 SHALL check, with PWM_DT_BRK_EN: brk_i pulse -> outputs 0 and brk_o=1 until brk_clr_i; brk_clr_i while brk_i=1 -> brk_o stays 1.
